// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared types and width helpers for the N-master system bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int bus_data_width(input int shift);
        return (2 ** shift) * 8;
    endfunction

    function automatic int line_addr_width(input int addr_width, input int shift);
        return addr_width - shift;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// arb_rr_pick: one-hot pick of the first set request at or after ptr, wrapping past N-1.
module arb_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: N-master arbiter for the shared 128-bit system bus,
// fixed-priority or round-robin, with per-master lock for multi-beat ownership.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS            = 2,
    parameter int BUS_ADDRESS_WIDTH    = 20,
    parameter int BUS_DATA_WIDTH_SHIFT = 4,
    parameter int RR_MODE              = MODE_RR,
    localparam int AW = line_addr_width(BUS_ADDRESS_WIDTH, BUS_DATA_WIDTH_SHIFT),
    localparam int DW = bus_data_width(BUS_DATA_WIDTH_SHIFT)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_MASTERS-1:0]    m_valid_i,
    input  logic [N_MASTERS-1:0]    m_lock_i,
    input  logic [N_MASTERS-1:0]    m_we_i,
    input  logic [N_MASTERS*AW-1:0] m_addr_i,
    input  logic [N_MASTERS*DW-1:0] m_data_i,
    output logic [N_MASTERS-1:0]    m_resp_valid_o,
    output logic [N_MASTERS-1:0]    grant_o,
    output logic [AW-1:0]           bus_addr_o,
    output logic [DW-1:0]           bus_data_o,
    output logic                   bus_we_o,
    output logic                   bus_valid_o,
    input  logic                   bus_valid_i,
    output logic                   err_o
);

    localparam int IW = idx_width(N_MASTERS);

    arb_state_t           state;
    logic [IW-1:0]        gidx;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        pick_ptr;
    logic [IW-1:0]        win_idx;
    logic [N_MASTERS-1:0] win;
    logic                 busy;
    logic                 hold;

    // Fixed priority is the round-robin picker anchored at master 0.
    assign pick_ptr = (RR_MODE == MODE_RR) ? ptr : '0;

    arb_rr_pick #(.N(N_MASTERS), .PW(IW)) u_pick (
        .req  (m_valid_i),
        .ptr  (pick_ptr),
        .grant(win)
    );

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < N_MASTERS; k++)
            if (win[k]) win_idx = IW'(k);
    end

    assign busy           = (state == BUSY);
    assign hold           = m_lock_i[gidx] & m_valid_i[gidx];
    assign m_resp_valid_o = (busy && bus_valid_i) ? grant_o : '0;
    assign bus_addr_o     = busy ? m_addr_i[int'(gidx)*AW +: AW] : '0;
    assign bus_data_o     = busy ? m_data_i[int'(gidx)*DW +: DW] : '0;
    assign bus_we_o       = busy & m_we_i[gidx];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            grant_o     <= '0;
            gidx        <= '0;
            ptr         <= '0;
            bus_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else if (state == IDLE) begin
            err_o <= err_o | bus_valid_i;
            if (|m_valid_i) begin
                state       <= BUSY;
                grant_o     <= win;
                gidx        <= win_idx;
                bus_valid_o <= 1'b1;
            end
        end else if (bus_valid_i && !hold) begin
            state       <= IDLE;
            grant_o     <= '0;
            bus_valid_o <= 1'b0;
            if (RR_MODE == MODE_RR)
                ptr <= (int'(gidx) == N_MASTERS - 1) ? '0 : gidx + IW'(1);
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of reset, single transfer, round-robin, fixed priority,
// lock, stray response and mid-transfer reset across three arbiter configurations.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic [1:0]   v2, l2, w2, r2, g2;
    logic [31:0]  a2;
    logic [255:0] d2;
    logic [15:0]  ba2;
    logic [127:0] bd2;
    logic         bv2, bwe2, bvo2, e2;

    logic [3:0]   l4, w4, v4r, v4f, r4r, r4f, g4r, g4f;
    logic [63:0]  a4;
    logic [511:0] d4;
    logic [15:0]  ba4r, ba4f;
    logic [127:0] bd4r, bd4f;
    logic         bv4r, bv4f, bwe4r, bwe4f, bvo4r, bvo4f, e4r, e4f;

    bus_arbiter #(.N_MASTERS(2), .RR_MODE(1)) u2 (
        .clk_i(clk), .rst_i(rst_n), .m_valid_i(v2), .m_lock_i(l2), .m_we_i(w2),
        .m_addr_i(a2), .m_data_i(d2), .m_resp_valid_o(r2), .grant_o(g2),
        .bus_addr_o(ba2), .bus_data_o(bd2), .bus_we_o(bwe2), .bus_valid_o(bvo2),
        .bus_valid_i(bv2), .err_o(e2)
    );

    bus_arbiter #(.N_MASTERS(4), .RR_MODE(1)) u4r (
        .clk_i(clk), .rst_i(rst_n), .m_valid_i(v4r), .m_lock_i(l4), .m_we_i(w4),
        .m_addr_i(a4), .m_data_i(d4), .m_resp_valid_o(r4r), .grant_o(g4r),
        .bus_addr_o(ba4r), .bus_data_o(bd4r), .bus_we_o(bwe4r), .bus_valid_o(bvo4r),
        .bus_valid_i(bv4r), .err_o(e4r)
    );

    bus_arbiter #(.N_MASTERS(4), .RR_MODE(0)) u4f (
        .clk_i(clk), .rst_i(rst_n), .m_valid_i(v4f), .m_lock_i(l4), .m_we_i(w4),
        .m_addr_i(a4), .m_data_i(d4), .m_resp_valid_o(r4f), .grant_o(g4f),
        .bus_addr_o(ba4f), .bus_data_o(bd4f), .bus_we_o(bwe4f), .bus_valid_o(bvo4f),
        .bus_valid_i(bv4f), .err_o(e4f)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    logic [3:0]   rr_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [127:0] wdat [3] = '{128'hDEAD_BEEF_0000_0000_0000_0000_0000_0010,
                               128'hDEAD_BEEF_0000_0000_0000_0000_0000_0011,
                               128'hDEAD_BEEF_0000_0000_0000_0000_0000_0012};

    initial begin
        v2 = '0; l2 = '0; w2 = '0; a2 = '0; d2 = '0; bv2 = 1'b0;
        l4 = '0; w4 = '0; a4 = '0; d4 = '0; v4r = '0; v4f = '0; bv4r = 1'b0; bv4f = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", g2, 0);
        chk("rst_bvo", bvo2, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_grant", g2, 0);
        chk("idle_bvo", bvo2, 0);
        chk("idle_we", bwe2, 0);
        chk("idle_addr", ba2, 0);
        chk("idle_data", bd2, 0);
        chk("idle_resp", r2, 0);
        chk("idle_err", e2, 0);
        chk("idle_grant4", g4r, 0);

        // single read by master 1
        a2 = {16'h01A3, 16'h0000};
        v2 = 2'b10;
        #1 chk("single_pre_bvo", bvo2, 0);
        tick();
        chk("single_grant", g2, 2'b10);
        chk("single_bvo", bvo2, 1);
        chk("single_addr", ba2, 16'h01A3);
        chk("single_we", bwe2, 0);
        chk("single_resp_early", r2, 0);
        tick();
        tick();
        tick();
        chk("single_hold_grant", g2, 2'b10);
        bv2 = 1'b1;
        #1 chk("single_resp", r2, 2'b10);
        tick();
        bv2 = 1'b0;
        v2 = 2'b00;
        #1 chk("single_idle_grant", g2, 0);
        chk("single_idle_bvo", bvo2, 0);
        chk("single_idle_resp", r2, 0);

        // round-robin rotation with all four masters requesting
        v4r = 4'hF;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr_grant%0d", k), g4r, rr_exp[k]);
            chk($sformatf("rr_bvo%0d", k), bvo4r, 1);
            bv4r = 1'b1;
            #1 chk($sformatf("rr_resp%0d", k), r4r, rr_exp[k]);
            tick();
            bv4r = 1'b0;
            if (k == 5) v4r = '0;
            #1 chk($sformatf("rr_bubble%0d", k), g4r, 0);
        end
        chk("rr_addr", ba4r, 0);
        chk("rr_data", bd4r, 0);
        chk("rr_we", bwe4r, 0);

        // fixed priority: m0 beats m2 every time until m0 drops
        v4f = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("fx_grant%0d", k), g4f, 4'b0001);
            bv4f = 1'b1;
            #1 chk($sformatf("fx_resp%0d", k), r4f, 4'b0001);
            tick();
            bv4f = 1'b0;
            if (k == 3) v4f = 4'b0100;
            #1 chk($sformatf("fx_bubble%0d", k), g4f, 0);
        end
        tick();
        chk("fx_grant_m2", g4f, 4'b0100);
        chk("fx_addr", ba4f, 0);
        chk("fx_data", bd4f, 0);
        chk("fx_we", bwe4f, 0);
        chk("fx_bvo", bvo4f, 1);
        bv4f = 1'b1;
        #1 chk("fx_resp_m2", r4f, 4'b0100);
        tick();
        bv4f = 1'b0;
        v4f = '0;
        #1 chk("fx_end_grant", g4f, 0);

        // locked three-write burst by master 1 while master 0 waits
        v2 = 2'b10; l2 = 2'b10; w2 = 2'b10;
        a2 = {16'h0010, 16'h0055};
        d2 = {wdat[0], 128'h0};
        tick();
        chk("lock_grant0", g2, 2'b10);
        v2 = 2'b11;
        #1 chk("lock_addr0", ba2, 16'h0010);
        chk("lock_we0", bwe2, 1);
        chk("lock_data0", bd2, wdat[0]);
        bv2 = 1'b1;
        #1 chk("lock_resp0", r2, 2'b10);
        for (int k = 1; k < 3; k++) begin
            tick();
            a2[31:16] = 16'h0010 + 16'(k);
            d2[255:128] = wdat[k];
            if (k == 2) l2 = 2'b00;
            #1 chk($sformatf("lock_grant%0d", k), g2, 2'b10);
            chk($sformatf("lock_bvo%0d", k), bvo2, 1);
            chk($sformatf("lock_addr%0d", k), ba2, 16'h0010 + 16'(k));
            chk($sformatf("lock_data%0d", k), bd2, wdat[k]);
            chk($sformatf("lock_resp%0d", k), r2, 2'b10);
        end
        tick();
        bv2 = 1'b0;
        v2 = 2'b01;
        #1 chk("lock_bubble", g2, 0);
        chk("lock_bubble_bvo", bvo2, 0);
        tick();
        chk("lock_m0_grant", g2, 2'b01);
        chk("lock_m0_addr", ba2, 16'h0055);
        chk("lock_m0_we", bwe2, 0);
        bv2 = 1'b1;
        #1 chk("lock_m0_resp", r2, 2'b01);
        tick();
        bv2 = 1'b0;
        v2 = 2'b00;
        w2 = 2'b00;
        #1 chk("lock_end_grant", g2, 0);

        // stray response while idle, then reset in the middle of a transfer
        chk("pre_stray_err", e2, 0);
        bv2 = 1'b1;
        #1 chk("stray_resp", r2, 0);
        tick();
        bv2 = 1'b0;
        #1 chk("stray_err", e2, 1);
        chk("stray_grant", g2, 0);
        tick();
        chk("stray_err_sticky", e2, 1);
        v2 = 2'b01;
        tick();
        chk("midrst_grant_pre", g2, 2'b01);
        chk("rr4_err", e4r, 0);
        chk("fx4_err", e4f, 0);
        bv2 = 1'b1;
        rst_n = 1'b0;
        #1 chk("midrst_grant", g2, 0);
        chk("midrst_err", e2, 0);
        chk("midrst_bvo", bvo2, 0);
        chk("midrst_resp", r2, 0);
        tick();
        chk("midrst_resp_hold", r2, 0);
        bv2 = 1'b0;
        v2 = 2'b00;
        rst_n = 1'b1;
        tick();
        chk("post_rst_grant", g2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised N-master arbiter for the shared 128-bit system bus. Generalises the two-cache arbiter to N_MASTERS requesters.
- Selectable fixed-priority or round-robin arbitration.
- Per-master lock, so a master can hold the bus for multi-beat flushes.
- Sits between the icache, dcache and future masters (DMA, debug) and the single bus port of cpu.

Parameters:
- N_MASTERS, 2, number of requesters (2..8).
- BUS_ADDRESS_WIDTH, 20, byte-address width of the bus.
- BUS_DATA_WIDTH_SHIFT, 4, log2 of the bus width in bytes. Bus data width is 8*2^SHIFT = 128.
- RR_MODE, 1, selects arbitration: 0 = fixed priority (master 0 highest), 1 = round-robin.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- m_valid_i  in  N_MASTERS  per-master request valid.
- m_lock_i  in  N_MASTERS  per-master request to keep the grant after the current response.
- m_we_i  in  N_MASTERS  per-master write enable.
- m_addr_i  in  N_MASTERS*AW  packed line addresses, AW = BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT. Master k occupies slice [k*AW +: AW].
- m_data_i  in  N_MASTERS*128  packed write data, same slicing.
- m_resp_valid_o  out  N_MASTERS  response pulse to the granted master.
- grant_o  out  N_MASTERS  one-hot current grant (all zero when idle).
- bus_addr_o  out  AW  bus line address.
- bus_data_o  out  128  bus write data.
- bus_we_o  out  1  bus write enable.
- bus_valid_o  out  1  bus request valid.
- bus_valid_i  in  1  bus response valid (read data travels on the shared bus_data_i, outside this block).
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - grant_o=0, bus_valid_o=0, bus_we_o=0, bus_addr_o=0, bus_data_o=0, m_resp_valid_o=0.
  - err_o=0; round-robin pointer = 0.
- States:
  - IDLE: no master owns the bus.
  - BUSY: one master owns the bus and its request is outstanding.
- IDLE -> BUSY:
  - Taken when any m_valid_i bit is set.
  - The winner is computed combinationally. Fixed mode: lowest index wins. RR mode: first set bit at or after the pointer, with wrap from N_MASTERS-1 to 0.
  - grant_o is registered, so it appears the next cycle. Request-to-bus_valid_o latency is 1 cycle.
- In BUSY:
  - bus_valid_o=1 (registered).
  - bus_addr_o, bus_data_o and bus_we_o are combinational muxes of the granted master's slice.
  - Masters hold valid, addr, we and data stable until their response.
- Response (BUSY and bus_valid_i=1):
  - m_resp_valid_o[g]=1 in the same cycle, combinationally; all other bits are 0.
  - If m_lock_i[g]=1 and m_valid_i[g]=1 in that cycle, stay in BUSY with grant unchanged.
  - Otherwise go to IDLE next cycle. In RR mode the pointer becomes (g+1) mod N_MASTERS.
  - There is exactly one idle bubble before the next grant.
- Abandoned grant: if m_valid_i[g] drops in BUSY before a response, the grant is still held until bus_valid_i. No abort is supported.
- Protocol error: bus_valid_i=1 while IDLE sets err_o. err_o is cleared only by reset; the stray response is otherwise ignored.
- Requests arriving during BUSY are queued implicitly: they are evaluated in the next IDLE cycle.
- Simultaneous requests in IDLE: exactly one grant, per the mode rule. Never multiple bits in grant_o.
- Round-robin fairness: with all masters requesting continuously and lock low, grants rotate 0,1,...,N-1,0 with no master skipped.
- Reset asserted mid-BUSY: the outstanding transaction is dropped and no m_resp_valid_o is produced. Bus-side cleanup is the responsibility of the slave reset.

Decomposition:
- Shared package holds:
  - the arbitration state enum (IDLE, BUSY);
  - BUS_DATA_WIDTH = (2**BUS_DATA_WIDTH_SHIFT)*8;
  - the AW derivation;
  - the RR_MODE encodings.
- One sub-module, arb_rr_pick: combinational pointer-based one-hot picker with wrap. Fixed mode instantiates it with pointer tied to 0.

Test Plan:
- Reset then idle: rst_i=0 for 3 cycles, then released with no requests -> all outputs 0, grant_o=0, err_o=0.
- Single master: N=2, m1 read at addr 0x1A3, response after 4 cycles -> bus_valid_o=1 from cycle 1; bus_addr_o=0x1A3, bus_we_o=0; m_resp_valid_o=2'b10 in the response cycle; IDLE next cycle.
- RR fairness: N=4, RR_MODE=1, all m_valid_i=1, 1-cycle responses -> grant order 0,1,2,3,0,1; one idle cycle between grants.
- Fixed priority: RR_MODE=0, m0 and m2 both request continuously -> m0 granted every transaction, m2 never granted while m0 is valid.
- Lock: m1 lock=1 for 3 writes (data 0xDEAD..., addrs 0x10, 0x11, 0x12) while m0 also requests -> m1 holds grant for all 3 writes with no idle bubble; m0 granted after lock drops.
- Stray response and mid-op reset: bus_valid_i=1 while idle -> err_o=1 and stays 1. Then rst_i=0 during BUSY -> grant_o=0 and err_o=0 immediately, and no m_resp_valid_o pulse.
